// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and helpers for the VGA timing generator and its callers.
package vga_timing_gen_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam bit VGA_HSYNC_POL = 1'b0;
  localparam bit VGA_VSYNC_POL = 1'b0;

  localparam int unsigned VGA_CW = 10;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with registered count, active and sync flags decoded
// from the value the counter is moving to.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = VGA_HSYNC_POL,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_width
    $error("vga_axis_counter: ACTIVE, FP, SYNC and BP must all be non-zero");
  end
  if (CW == 0 || ((TOTAL - 1) >> CW) != 0) begin : g_bad_cw
    $error("vga_axis_counter: TOTAL-1 does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // The internal counter parks at LAST in reset so the first advance lands on 0,
  // while the visible count reads 0 throughout reset.
  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt = wrap ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= LAST;
      count  <= '0;
      active <= 1'b0;
      sync   <= ~POL;
    end else if (advance) begin
      cnt    <= cnt_nxt;
      count  <= cnt_nxt;
      active <= (cnt_nxt < ACT_END);
      sync   <= (cnt_nxt >= SYNC_LO && cnt_nxt < SYNC_HI) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters plus line/frame pulses.
// Optional line-match interrupt enabled by defining VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HSYNC_POL = VGA_HSYNC_POL,
  parameter bit          VSYNC_POL = VGA_VSYNC_POL,
  parameter int unsigned CW        = VGA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_pixel,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_LINE_IRQ_EN
  ,
  input  logic [CW-1:0] irq_line,
  output logic          line_irq
`endif
);

  logic h_wrap, v_wrap;
  logic h_active, v_active;
  logic v_advance;

  assign v_advance = clk_pixel & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (clk_pixel),
    .count   (x),
    .wrap    (h_wrap),
    .active  (h_active),
    .sync    (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (v_advance),
    .count   (y),
    .wrap    (v_wrap),
    .active  (v_active),
    .sync    (vsync)
  );

  // Both flags are flops updated on the same edge, so de tracks the new count directly.
  assign de = h_active & v_active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= v_advance;
      frame_start <= v_advance & v_wrap;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CW-1:0] y_new;

  // y still reads 0 right after reset while the counter is parked, but v_wrap is set
  // then, so the incoming line number is still correct.
  always_comb begin
    y_new = v_wrap ? '0 : y + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= v_advance & (y_new == irq_line);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 16x8 raster, active-low and active-high syncs.
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned CW = 10;
  localparam int HT = 16;
  localparam int VT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_pixel;
  logic [CW-1:0] irq_line;

  logic          hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;
  logic          hsync_p, vsync_p, de_p, line_start_p, frame_start_p;
  logic [CW-1:0] x_p, y_p;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic          line_irq, line_irq_p;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .clk_pixel(clk_pixel),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_LINE_IRQ_EN
    , .irq_line(irq_line), .line_irq(line_irq)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(CW)
  ) u_dut_p (
    .clk(clk), .rst(rst), .clk_pixel(clk_pixel),
    .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .x(x_p), .y(y_p),
    .line_start(line_start_p), .frame_start(frame_start_p)
`ifdef VGA_TIMING_LINE_IRQ_EN
    , .irq_line(irq_line), .line_irq(line_irq_p)
`endif
  );

  typedef struct {
    int x;
    int y;
    bit de;
    bit hsa;
    bit vsa;
    bit ls;
    bit fs;
    bit irq;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   m_hc = HT - 1;
  int   m_vc = VT - 1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fs;
  int   irq_cnt;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit pix);
    exp_t e;
    rst       = r;
    clk_pixel = pix;
    if (!r) begin
      m_hc = HT - 1;
      m_vc = VT - 1;
      m = '{x: 0, y: 0, de: 1'b0, hsa: 1'b0, vsa: 1'b0, ls: 1'b0, fs: 1'b0, irq: 1'b0};
    end else begin
      m.ls  = 1'b0;
      m.fs  = 1'b0;
      m.irq = 1'b0;
      if (pix) begin
        if (m_hc == HT - 1) begin
          m_hc = 0;
          m.ls = 1'b1;
          if (m_vc == VT - 1) begin
            m_vc = 0;
            m.fs = 1'b1;
          end else begin
            m_vc++;
          end
          m.irq = (m_vc == int'(irq_line));
        end else begin
          m_hc++;
        end
        m.x   = m_hc;
        m.y   = m_vc;
        m.de  = (m_hc < int'(HA)) && (m_vc < int'(VA));
        m.hsa = (m_hc >= int'(HA + HF)) && (m_hc < int'(HA + HF + HS));
        m.vsa = (m_vc >= int'(VA + VF)) && (m_vc < int'(VA + VF + VS));
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("x",           int'(x),        e.x);
    check("y",           int'(y),        e.y);
    check("de",          int'(de),       int'(e.de));
    check("hsync_low",   int'(hsync),    int'(!e.hsa));
    check("vsync_low",   int'(vsync),    int'(!e.vsa));
    check("line_start",  int'(line_start),  int'(e.ls));
    check("frame_start", int'(frame_start), int'(e.fs));
    check("x_pol1",      int'(x_p),      e.x);
    check("de_pol1",     int'(de_p),     int'(e.de));
    check("hsync_high",  int'(hsync_p),  int'(e.hsa));
    check("vsync_high",  int'(vsync_p),  int'(e.vsa));
    check("fs_pol1",     int'(frame_start_p), int'(e.fs));
`ifdef VGA_TIMING_LINE_IRQ_EN
    check("line_irq",    int'(line_irq), int'(e.irq));
    check("line_irq_p1", int'(line_irq_p), int'(e.irq));
`endif
  endtask

  initial begin
    rst       = 1'b0;
    clk_pixel = 1'b0;
    irq_line  = CW'(3);

    // Reset with and without strobe.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Released but no strobe yet: still in reset state.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // First strobe lands on (0,0) with both pulses.
    step(1'b1, 1'b1);
    check("first_x0", int'(x), 0);
    check("first_fs", int'(frame_start), 1);
    last_fs = cyc;

    // clk_pixel tied high: two frames, frame_start period.
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1, 1'b1);
      if (frame_start) begin
        check("fs_period", cyc - last_fs, HT * VT);
        last_fs = cyc;
      end
    end

    // Strobe every 4th clk across more than a frame.
    for (int i = 0; i < 600; i++) begin
      step(1'b1, (i % 4) == 0);
    end

    // Reset mid-frame at (7,2) with clk_pixel low.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * HT + 7; i++) begin
      step(1'b1, 1'b1);
    end
    check("pre_reset_x", int'(x), 7);
    check("pre_reset_y", int'(y), 2);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Line interrupt: in-range line fires once per frame, out-of-range never.
    irq_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b1);
`ifdef VGA_TIMING_LINE_IRQ_EN
      irq_cnt += int'(line_irq);
`endif
    end
`ifdef VGA_TIMING_LINE_IRQ_EN
    check("irq_count_3", irq_cnt, 1);
`endif
    irq_line = CW'(9);
    irq_cnt  = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b1);
`ifdef VGA_TIMING_LINE_IRQ_EN
      irq_cnt += int'(line_irq);
`endif
    end
`ifdef VGA_TIMING_LINE_IRQ_EN
    check("irq_count_9", irq_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
